// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the 8-bit core fetch/decode controller.
package cpu_defs;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned IMM_W   = 6;
    localparam int unsigned REG_W   = 3;
    localparam int unsigned EXT_W   = 8;

    // Instruction field positions
    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 9;
    localparam int unsigned RS_MSB  = 8;
    localparam int unsigned RS_LSB  = 6;
    localparam int unsigned RT_MSB  = 5;
    localparam int unsigned RT_LSB  = 3;
    localparam int unsigned IMM_MSB = 5;
    localparam int unsigned IMM_LSB = 0;

    // Opcodes; 0xB..0xE are unassigned and decode as illegal
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_ANDI = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CL_NOP     = 3'd0,
        CL_ALU     = 3'd1,
        CL_LD      = 3'd2,
        CL_ST      = 3'd3,
        CL_BEQ     = 3'd4,
        CL_JMP     = 3'd5,
        CL_HALT    = 3'd6,
        CL_ILLEGAL = 3'd7
    } iclass_e;

    typedef struct packed {
        logic    cs;
        alu_op_e alu_op;
        logic    alu_src_imm;
        iclass_e iclass;
    } dec_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decoder: extension mode, ALU op, operand select, instruction class.
module instr_decoder
    import cpu_defs::*;
(
    input  logic [3:0] i_opcode,
    output dec_t       o_dec
);

    // Opcode to control fields; anything unlisted is illegal
    always_comb begin
        o_dec.cs          = 1'b0;
        o_dec.alu_op      = ALU_ADD;
        o_dec.alu_src_imm = 1'b0;
        o_dec.iclass      = CL_NOP;
        case (i_opcode)
            OP_NOP:  o_dec.iclass = CL_NOP;
            OP_ADD:  o_dec.iclass = CL_ALU;
            OP_SUB: begin
                o_dec.iclass = CL_ALU;
                o_dec.alu_op = ALU_SUB;
            end
            OP_AND: begin
                o_dec.iclass = CL_ALU;
                o_dec.alu_op = ALU_AND;
            end
            OP_OR: begin
                o_dec.iclass = CL_ALU;
                o_dec.alu_op = ALU_OR;
            end
            OP_ADDI: begin
                o_dec.iclass      = CL_ALU;
                o_dec.cs          = 1'b1;
                o_dec.alu_src_imm = 1'b1;
            end
            OP_ANDI: begin
                o_dec.iclass      = CL_ALU;
                o_dec.alu_op      = ALU_AND;
                o_dec.alu_src_imm = 1'b1;
            end
            OP_LD: begin
                o_dec.iclass      = CL_LD;
                o_dec.cs          = 1'b1;
                o_dec.alu_src_imm = 1'b1;
            end
            OP_ST: begin
                o_dec.iclass      = CL_ST;
                o_dec.cs          = 1'b1;
                o_dec.alu_src_imm = 1'b1;
            end
            OP_BEQ: begin
                o_dec.iclass = CL_BEQ;
                o_dec.cs     = 1'b1;
                o_dec.alu_op = ALU_SUB;
            end
            OP_JMP:  o_dec.iclass = CL_JMP;
            OP_HALT: o_dec.iclass = CL_HALT;
            default: o_dec.iclass = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Multi-cycle fetch/decode controller: FSM, PC and instruction register.
module fetch_decode_ctrl
    import cpu_defs::*;
#(
    parameter int unsigned PC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        imem_data,
    input  logic               imem_valid,
    input  logic               dmem_valid,
    input  logic               alu_zero,
    input  logic [7:0]         ext_immediate,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_rd,
    output logic [5:0]         immediate,
    output logic               CS,
    output logic [2:0]         rd_addr,
    output logic [2:0]         rs_addr,
    output logic [2:0]         rt_addr,
    output logic [2:0]         alu_op,
    output logic               alu_src_imm,
    output logic               reg_we,
    output logic               mem_rd,
    output logic               mem_we,
    output logic               halted,
    output logic               illegal
);

    state_e               r_state;
    logic [PC_W-1:0]      r_pc;
    logic [INSTR_W-1:0]   r_ir;
    logic                 r_imem_rd;
    logic                 r_reg_we;
    logic                 r_mem_rd;
    logic                 r_mem_we;
    logic                 r_halted;
    logic                 r_illegal;

    dec_t                 w_dec;
    logic [PC_W-1:0]      w_ext_pc;

    instr_decoder u_instr_decoder (
        .i_opcode (r_ir[OPC_MSB:OPC_LSB]),
        .o_dec    (w_dec)
    );

    assign w_ext_pc = PC_W'(ext_immediate);

    // Sequencer: fetch handshake, decode, execute, data-memory wait, halt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_pc      <= '0;
            r_ir      <= '0;
            r_imem_rd <= 1'b0;
            r_reg_we  <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_reg_we  <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    if (r_imem_rd && imem_valid) begin
                        r_ir      <= imem_data;
                        r_pc      <= r_pc + PC_W'(1);
                        r_imem_rd <= 1'b0;
                        r_state   <= ST_DECODE;
                    end else begin
                        r_imem_rd <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    r_state <= ST_EXEC;
                    case (w_dec.iclass)
                        CL_ALU:     r_reg_we  <= 1'b1;
                        CL_ILLEGAL: r_illegal <= 1'b1;
                        default:    ;
                    endcase
                end
                ST_EXEC: begin
                    r_state   <= ST_FETCH;
                    r_imem_rd <= 1'b1;
                    case (w_dec.iclass)
                        CL_LD: begin
                            r_state   <= ST_MEM;
                            r_imem_rd <= 1'b0;
                            r_mem_rd  <= 1'b1;
                        end
                        CL_ST: begin
                            r_state   <= ST_MEM;
                            r_imem_rd <= 1'b0;
                            r_mem_we  <= 1'b1;
                        end
                        CL_BEQ: begin
                            if (alu_zero) begin
                                r_pc <= r_pc + w_ext_pc;
                            end
                        end
                        CL_JMP:  r_pc <= w_ext_pc;
                        CL_HALT: begin
                            r_state   <= ST_HALT;
                            r_imem_rd <= 1'b0;
                            r_halted  <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    if (dmem_valid) begin
                        r_mem_rd  <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_imem_rd <= 1'b1;
                        r_state   <= ST_FETCH;
                    end
                end
                ST_HALT: r_halted <= 1'b1;
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    assign imem_addr   = r_pc;
    assign imem_rd     = r_imem_rd;
    assign immediate   = r_ir[IMM_MSB:IMM_LSB];
    assign rd_addr     = r_ir[RD_MSB:RD_LSB];
    assign rs_addr     = r_ir[RS_MSB:RS_LSB];
    assign rt_addr     = r_ir[RT_MSB:RT_LSB];
    assign CS          = w_dec.cs;
    assign alu_op      = w_dec.alu_op;
    assign alu_src_imm = w_dec.alu_src_imm;
    // Load write-back coincides with the cycle the data arrives
    assign reg_we      = r_reg_we | (r_mem_rd & dmem_valid);
    assign mem_rd      = r_mem_rd;
    assign mem_we      = r_mem_we;
    assign halted      = r_halted;
    assign illegal     = r_illegal;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Self-checking bench for fetch_decode_ctrl with an instruction-level reference model.
module tb_fetch_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_data;
    logic        imem_valid;
    logic        dmem_valid;
    logic        alu_zero;
    logic [7:0]  ext_immediate;
    logic [7:0]  imem_addr;
    logic        imem_rd;
    logic [5:0]  immediate;
    logic        CS;
    logic [2:0]  rd_addr, rs_addr, rt_addr, alu_op;
    logic        alu_src_imm, reg_we, mem_rd, mem_we, halted, illegal;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  m_pc;
    bit          noise_en = 1'b0;

    fetch_decode_ctrl #(.PC_W(8)) dut (
        .clk(clk), .rst(rst), .imem_data(imem_data), .imem_valid(imem_valid),
        .dmem_valid(dmem_valid), .alu_zero(alu_zero), .ext_immediate(ext_immediate),
        .imem_addr(imem_addr), .imem_rd(imem_rd), .immediate(immediate), .CS(CS),
        .rd_addr(rd_addr), .rs_addr(rs_addr), .rt_addr(rt_addr), .alu_op(alu_op),
        .alu_src_imm(alu_src_imm), .reg_we(reg_we), .mem_rd(mem_rd), .mem_we(mem_we),
        .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic nz();
        return noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    // Issue one instruction with iw fetch-wait and dw data-wait cycles; check against the model
    task automatic run_instr(input logic [15:0] ins, input int iw, input int dw, input logic z);
        logic [3:0] op;
        logic [5:0] imm;
        logic       cs, src;
        logic [7:0] ext, npc;
        logic [2:0] aop;
        bit         aop_known, done;
        int exp_lat, exp_we, exp_rd, exp_mw, exp_ill;
        int phase, cyc, fcnt, mcnt, lat, n_we, n_rd, n_mw, n_ill, we_at;

        op  = ins[15:12];
        imm = ins[5:0];
        cs  = (op == 4'h5 || op == 4'h7 || op == 4'h8 || op == 4'h9);
        src = (op >= 4'h5 && op <= 4'h8);
        ext = cs ? {{2{imm[5]}}, imm} : {2'b00, imm};
        aop_known = (op >= 4'h1 && op <= 4'h9);
        case (op)
            4'h2, 4'h9: aop = 3'd1;
            4'h3, 4'h6: aop = 3'd2;
            4'h4:       aop = 3'd3;
            default:    aop = 3'd0;
        endcase
        exp_lat = iw + ((op == 4'h7 || op == 4'h8) ? 4 + dw : 3);
        exp_we  = ((op >= 4'h1 && op <= 4'h7)) ? 1 : 0;
        exp_rd  = (op == 4'h7) ? dw + 1 : 0;
        exp_mw  = (op == 4'h8) ? dw + 1 : 0;
        exp_ill = (op >= 4'hB && op <= 4'hE) ? 1 : 0;
        npc = m_pc + 8'd1;
        if (op == 4'h9 && z) npc = npc + ext;
        if (op == 4'hA) npc = ext;

        imem_data = ins; alu_zero = z; ext_immediate = ext;
        phase = 0; cyc = 0; fcnt = 0; mcnt = 0; lat = 0;
        n_we = 0; n_rd = 0; n_mw = 0; n_ill = 0; we_at = -1; done = 1'b0;

        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (phase == 0) begin
                imem_valid = 1'b0;
                dmem_valid = nz();
                if (imem_rd === 1'b1) begin
                    chk("fetch_addr", 32'(imem_addr), 32'(m_pc));
                    phase = 1;
                end
            end
            if (phase == 1) begin
                lat++;
                imem_valid = (fcnt == iw);
                fcnt++;
                dmem_valid = nz();
                #1;
                chk("no_strobe_in_fetch", 32'({reg_we, mem_rd, mem_we, illegal, halted}), 32'(0));
                if (imem_valid) phase = 2;
            end else if (phase == 2) begin
                if (imem_rd === 1'b1 || halted === 1'b1) begin
                    imem_valid = 1'b0;
                    dmem_valid = 1'b0;
                    done = 1'b1;
                end else begin
                    lat++;
                    imem_valid = nz();
                    if (mem_rd === 1'b1 || mem_we === 1'b1) begin
                        mcnt++;
                        dmem_valid = (mcnt == dw + 1);
                    end else begin
                        dmem_valid = nz();
                    end
                    #1;
                    if (reg_we === 1'b1) begin n_we++; we_at = lat; end
                    if (mem_rd === 1'b1) n_rd++;
                    if (mem_we === 1'b1) n_mw++;
                    if (illegal === 1'b1) n_ill++;
                    chk("decode_fields",
                        32'({CS, immediate, rd_addr, rs_addr, rt_addr, alu_src_imm}),
                        32'({cs, imm, ins[11:9], ins[8:6], ins[5:3], src}));
                    if (aop_known) chk("alu_op", 32'(alu_op), 32'(aop));
                end
            end
        end

        chk("completed_in_budget", 32'(done), 32'(1));
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("reg_we_count", 32'(n_we), 32'(exp_we));
        if (exp_we != 0) chk("reg_we_cycle", 32'(we_at), 32'(exp_lat));
        chk("mem_rd_cycles", 32'(n_rd), 32'(exp_rd));
        chk("mem_we_cycles", 32'(n_mw), 32'(exp_mw));
        chk("illegal_pulses", 32'(n_ill), 32'(exp_ill));
        m_pc = npc;
        if (op == 4'hF) chk("halted_set", 32'(halted), 32'(1));
        else            chk("next_pc", 32'(imem_addr), 32'(m_pc));
    endtask

    initial begin
        rst = 1'b1; imem_data = '0; imem_valid = 1'b0; dmem_valid = 1'b0;
        alu_zero = 1'b0; ext_immediate = '0; m_pc = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_imem_rd", 32'(imem_rd), 32'(0));
        chk("rst_strobes", 32'({reg_we, mem_rd, mem_we, illegal, halted}), 32'(0));
        chk("rst_pc", 32'(imem_addr), 32'(0));
        chk("rst_ir_nop", 32'({CS, immediate, alu_src_imm}), 32'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("first_cycle_imem_rd", 32'(imem_rd), 32'(1));

        // Directed instructions
        run_instr(16'h5A05, 0, 0, 1'b0);       // ADDI r5,r0,5
        run_instr(16'hA010, 0, 0, 1'b0);       // JMP 0x10
        run_instr(16'h923E, 0, 0, 1'b1);       // BEQ taken -> 0x0F
        run_instr(16'hA010, 1, 0, 1'b0);
        run_instr(16'h923E, 0, 0, 1'b0);       // BEQ not taken -> 0x11
        run_instr(16'hA03F, 0, 0, 1'b0);       // JMP 0x3F
        run_instr(16'hA000, 0, 0, 1'b0);
        run_instr(16'h903E, 0, 0, 1'b1);       // 0x01-2 -> 0xFF
        run_instr(16'h9001, 0, 0, 1'b1);       // wraps to 0x01
        run_instr(16'h7443, 0, 3, 1'b0);       // LD with 3 wait cycles
        run_instr(16'h8443, 2, 1, 1'b0);       // ST
        run_instr(16'hC000, 0, 0, 1'b0);       // illegal opcode
        run_instr(16'h0000, 0, 0, 1'b0);       // NOP

        // Randomized instructions with stray valids
        noise_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
            logic [3:0] rop;
            rop = 4'($urandom_range(0, 14));
            run_instr({rop, 12'($urandom)}, $urandom_range(0, 2), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)));
        end
        noise_en = 1'b0;

        // Reset in the middle of a load wait
        imem_data = 16'h7443; ext_immediate = 8'h03; dmem_valid = 1'b0;
        for (int i = 0; i < 10 && imem_rd !== 1'b1; i++) @(negedge clk);
        chk("ldrst_fetch_req", 32'(imem_rd), 32'(1));
        imem_valid = 1'b1;
        @(negedge clk);
        imem_valid = 1'b0;
        for (int i = 0; i < 10 && mem_rd !== 1'b1; i++) @(negedge clk);
        chk("ldrst_in_mem", 32'(mem_rd), 32'(1));
        #2 rst = 1'b1;
        #1;
        chk("ldrst_mem_rd_cleared", 32'({mem_rd, reg_we, imem_rd}), 32'(0));
        chk("ldrst_pc_cleared", 32'(imem_addr), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        m_pc = 8'h00;
        @(posedge clk); #1;
        chk("ldrst_refetch", 32'({imem_rd, imem_addr}), 32'({1'b1, 8'h00}));
        run_instr(16'h6E3F, 0, 0, 1'b0);       // ANDI after reset

        // Halt is absorbing
        run_instr(16'hF000, 0, 0, 1'b0);
        noise_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            imem_valid = nz();
            dmem_valid = nz();
            #1;
            chk("halt_no_fetch", 32'({imem_rd, halted}), 32'({1'b0, 1'b1}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_decode_ctrl.md
# fetch_decode_ctrl

Multi-cycle fetch/decode controller for the 8-bit core; the stage directly upstream of `Const_unit`. It fetches 16-bit instructions over a valid-qualified instruction-memory port, holds them in an instruction register, and drives `immediate[5:0]`/`CS` into `Const_unit`. It sequences register-file, ALU and data-memory strobes, and updates the PC, using `ext_immediate` returned from `Const_unit` for branches and jumps.

## Interface
- `PC_W`, 8, PC/instruction address width
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — asynchronous, active-high reset
- `imem_data` in 16 — instruction word, sampled when `imem_valid`=1
- `imem_valid` in 1 — instruction memory has returned `imem_data`
- `dmem_valid` in 1 — data access complete (LD data present / ST accepted)
- `alu_zero` in 1 — ALU result==0 (used by BEQ)
- `ext_immediate` in 8 — extended immediate from `Const_unit`
- `imem_addr` out PC_W — equals `pc`
- `imem_rd` out 1 — fetch request
- `immediate` out 6 — IR[5:0]
- `CS` out 1 — 1 = sign-extend, 0 = zero-extend
- `rd_addr`, `rs_addr`, `rt_addr` out 3 each — IR[11:9], IR[8:6], IR[5:3]
- `alu_op` out 3 — 0 ADD, 1 SUB, 2 AND, 3 OR
- `alu_src_imm` out 1 — ALU B operand = `ext_immediate`
- `reg_we`, `mem_rd`, `mem_we` out 1 each
- `halted`, `illegal` out 1 each

## Operation
- Instruction layout: [15:12] opcode, [11:9] rd, [8:6] rs, [5:0] imm (rt = [5:3] for R-type).
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR (R-type)
  - 5 ADDI (CS=1)
  - 6 ANDI (CS=0)
  - 7 LD rd←mem[rs+simm] (CS=1)
  - 8 ST mem[rs+simm]←rd (CS=1)
  - 9 BEQ if rd==rs then pc←pc+simm (CS=1)
  - A JMP pc←zext imm (CS=0)
  - F HALT
  - B–E illegal
- `CS`=0 for every opcode not listed with CS=1.
- FSM states:
  - FETCH: `imem_rd`=1. On `imem_valid`, load IR, pc←pc+1 → DECODE; otherwise stay.
  - DECODE: one cycle. Decode outputs settle from IR.
  - EXEC:
    - ALU/imm ops: `reg_we`=1 → FETCH
    - LD/ST: → MEM
    - BEQ: `alu_op`=SUB; if `alu_zero`, pc←pc+`ext_immediate` (mod 2^PC_W) → FETCH
    - JMP: pc←`ext_immediate` → FETCH
    - NOP → FETCH
    - illegal: `illegal`=1 for one cycle, then behaves as NOP
    - HALT → HALT
  - MEM: `mem_rd` (LD) or `mem_we` (ST) held high until `dmem_valid`. For LD, `reg_we`=1 in the `dmem_valid` cycle. Then → FETCH.
  - HALT: `halted`=1. Absorbing state, left only by `rst`.
- Decode outputs (`immediate`, `CS`, register addresses, `alu_op`, `alu_src_imm`) are combinational from IR and stable from DECODE until the next IR load.
- `alu_src_imm`=1 for ADDI/ANDI/LD/ST.
- LD/ST address: `alu_op`=ADD on rs + `ext_immediate`.

## Timing
- Reset values:
  - state FETCH, pc=0, IR=0 (decodes as NOP)
  - `reg_we`/`mem_rd`/`mem_we`/`illegal`/`halted`=0, `imem_rd`=0 while `rst`=1
- `imem_rd`=1 in the first cycle after `rst` deasserts.
- Latency with zero-wait memories (`imem_valid` and `dmem_valid` high in the request cycle):
  - ALU/branch/jump/NOP: 3 cycles
  - LD/ST: 4 cycles
  - Each memory wait cycle adds 1.
- `reg_we`, `mem_we` and `illegal` are never asserted for more than one instruction and never outside EXEC/MEM.
- PC wraps 0xFF→0x00 on increment. Branch addition also wraps.
- BEQ target is relative to the already-incremented pc.
- A `valid` arriving in a state that is not waiting for it is ignored.
- Asynchronous `rst` mid-instruction (including during MEM with `mem_we` high) immediately clears all strobes and returns to FETCH/pc=0. A partial store is acceptable; no write retry.

## Structure
- Shared package `cpu_defs`: opcode constants, `alu_op` encodings, FSM state encoding, instruction field positions.
- One sub-module: `instr_decoder` (combinational IR→`CS`, `alu_op`, `alu_src_imm`, instruction-class flags).
- Top level holds the FSM, PC and IR.

## Test plan
- Reset, then `imem_data`=0x5A05 (ADDI r5,r0,5) with immediate valid → `CS`=1, `immediate`=5, `alu_src_imm`=1, `reg_we` pulses in cycle 3, `imem_addr` then 0x01.
- BEQ 0x923E (imm=-2) at pc=0x10 with `alu_zero`=1 → next `imem_addr`=0x0F. Same with `alu_zero`=0 → 0x11.
- JMP 0xA03F → `CS`=0, next `imem_addr`=0x3F. BEQ at pc=0xFF, imm=+1 → wraps to 0x01.
- LD 0x7443 with `dmem_valid` delayed 3 cycles → `mem_rd` high 4 cycles, single `reg_we` in the final cycle; ST asserts `mem_we` only, no `reg_we`.
- Opcode 0xC → `illegal` pulses once, no strobes, fetch resumes. HALT 0xF000 → `halted`=1 and no further `imem_rd`.
- Assert `rst` during an LD wait → `mem_rd`=0 immediately, pc=0, fetch restarts at 0x00.
